// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-register in-order pipeline.
// Resolves four hazards: data-memory wait, divider occupancy, load-use,
// and taken-branch redirect. Also keeps a saturating count of PC-stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_div_start,
  input  logic             ex_br_taken,
  input  logic             mem_req_valid,
  input  logic             mem_ack,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  localparam int unsigned DCW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  typedef enum logic {
    RUN,
    DIV_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;

  logic mem_stall;
  logic div_stall;
  logic lu_hz;
  logic in_div_wait;
  logic cnt_zero;

  // Hazard detection from current inputs and divider state.
  always_comb begin
    mem_stall   = mem_req_valid & ~mem_ack;
    in_div_wait = (state_q == DIV_WAIT);
    cnt_zero    = (div_cnt_q == '0);
    // The done cycle itself is stall-free: EX advances while the FSM returns to RUN.
    div_stall   = (in_div_wait & ~cnt_zero) | (~in_div_wait & ex_div_start);
    lu_hz       = ex_is_load & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Divider FSM next-state; the count freezes while memory holds the pipe.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      RUN: begin
        if (ex_div_start && !mem_stall) begin
          state_d   = DIV_WAIT;
          div_cnt_d = DCW'(DIV_LAT - 2);
        end
      end
      DIV_WAIT: begin
        // A memory stall in the done cycle keeps the divide in EX, so the
        // return to RUN waits too; otherwise the frozen ex_div_start would
        // relaunch the same divide.
        if (!mem_stall) begin
          if (cnt_zero) state_d = RUN;
          else          div_cnt_d = div_cnt_q - DCW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Prioritised stall/flush outputs, forced to flush-all during reset.
  always_comb begin
    stall_o  = '0;
    flush_o  = '0;
    div_busy = 1'b0;
    div_done = 1'b0;
    if (rst) begin
      flush_o = '1;
    end else begin
      div_busy = in_div_wait;
      div_done = in_div_wait & cnt_zero;
      if (mem_stall) begin
        stall_o = 5'b01111;
        flush_o = 5'b10000;
      end else if (div_stall) begin
        stall_o = 5'b00111;
        flush_o = 5'b01000;
      end else if (ex_br_taken) begin
        flush_o = 5'b00110;
      end else if (lu_hz) begin
        stall_o = 5'b00011;
        flush_o = 5'b00100;
      end
    end
  end

  // Saturating PC-stall cycle counter.
  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (stall_o[0] && (perf_stall_cnt_q != '1))
      perf_stall_cnt_d = perf_stall_cnt_q + CNT_W'(1);
  end

  assign perf_stall_cnt = perf_stall_cnt_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      div_cnt_q        <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      div_cnt_q        <= div_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

endmodule
